ysyx_22050243_lsu: RTL
======================

# ysyx_22050243_lsu

Parametrised load/store unit between the MEM stage and the data memory port of the ysyx_22050243 core. It replaces a single-cycle, full-width combinational access with a valid/ready request/response transaction. Each transaction performs byte/half/word/double sizing, write-mask generation, lane shifting, sign/zero extension and misalignment detection. The memory side has a configurable fixed latency, so the same unit serves the DPI-C pmem model (LATENCY=0) and slower SRAM/bus models.

## Interface
- XLEN, 64: data width, 32 or 64; lane count NB = XLEN/8, offset bits OB = log2(NB).
- ADDR_WIDTH, 64: address width.
- LATENCY, 0: memory cycles from the mem_en cycle to mem_rdata valid, 0..15.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  0=B, 1=H, 2=W, 3=D.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request.
- mem_en  out  1  one-cycle memory access strobe.
- mem_wen  out  1  write qualifier, valid with mem_en.
- mem_addr  out  ADDR_WIDTH  req_addr with the low OB bits cleared.
- mem_wmask  out  NB  byte enables.
- mem_wdata  out  XLEN  store data shifted into its lanes.
- mem_rdata  in  XLEN  full-width read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid: latch addr, size, wen, unsigned and wdata.
  - Aligned request: go to ACCESS.
  - Misaligned request: go to RESP with err=1.
- Misaligned: addr mod 2^size != 0, or size=3 with XLEN=32. No memory access is issued.
- ACCESS: mem_en=1 for exactly one cycle.
  - LATENCY=0: capture mem_rdata this cycle and go to RESP.
  - LATENCY>0: load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter. At 0, capture mem_rdata in that cycle and go to RESP.
- RESP: resp_valid=1. Hold resp_rdata and resp_err stable until resp_ready, then go to IDLE.
- Offset off = addr[OB-1:0].
- mem_wmask = ((1<<(1<<size))-1) << off. Loads drive mem_wmask=0.
- mem_wdata = req_wdata << (8*off). Unused lanes are don't-care; the bench checks only masked bytes.
- Loads: take the raw value mem_rdata >> (8*off) and keep its low 8<<size bits.
  - Extend to XLEN: sign-extend from the top kept bit unless req_unsigned.
  - size=D (XLEN=64) ignores req_unsigned.
- Stores complete through the same response path with resp_rdata=0 and resp_err=0.
- mem_* outputs are 0 whenever mem_en=0.

## Timing
- Request accepted in cycle T (req_valid & req_ready).
- mem_en high in T+1; mem_rdata sampled in T+1+LATENCY.
- resp_valid rises in T+2+LATENCY and is registered.
- Misaligned: resp_valid in T+1, no mem_en.
- Response handshake in cycle R: resp_valid drops in R+1 and req_ready=1 from R+1. Next request start-to-start is at minimum LATENCY+3 cycles.
- resp_ready held low: the unit stays in RESP indefinitely with outputs unchanged. req_ready stays 0.
- req_valid while busy: ignored (not latched). The requester must hold it.
- resp_ready high before resp_valid: has no effect.
- Reset asserted:
  - State goes to IDLE immediately (asynchronously).
  - resp_valid, resp_err, resp_rdata, mem_en, mem_wen, mem_addr, mem_wmask and mem_wdata go to 0.
  - req_ready=1, but no request is accepted while rst is high.
- Reset during ACCESS, WAIT or RESP: the transaction is dropped with no response. The first request after deassert is accepted normally.

## Test plan
- XLEN=64, LATENCY=0, load W at 0x80000004, mem_rdata=0x8000_0001_1234_5678, unsigned=0 -> mem_addr=0x80000000 and mem_en in T+1; resp_rdata=0xFFFF_FFFF_8000_0001 in T+2.
- Store H at 0x80000006, wdata=0xABCD -> mem_wmask=0xC0, mem_wdata[63:48]=0xABCD, mem_wen=1 for one cycle; resp_valid with rdata=0 and err=0.
- Load H at 0x80000003 -> resp_err=1 in T+1, mem_en never asserted; req_ready=1 the cycle after the response handshake.
- LATENCY=3, load B unsigned at 0x80000007, mem_rdata[63:56]=0xF0 in T+4 -> resp_rdata=0xF0 in T+5; resp_ready held low 4 cycles: data stable, req_ready=0.
- XLEN=32: a D load -> resp_err=1. A W load at 0x10 with mem_rdata=0xDEADBEEF -> resp_rdata=0xDEADBEEF.
- rst pulsed in WAIT with LATENCY=5 -> all outputs 0 during reset, no resp_valid afterwards; a following B load completes in LATENCY+2 cycles.

Source files
------------

// File: rtl/ysyx_22050243_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ysyx_22050243_lsu : valid/ready load/store unit, fixed-latency mem port  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ysyx_22050243_lsu #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN/8-1:0]     mem_wmask,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam logic [3:0] C_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_wen;
    logic                  r_uns;
    logic [XLEN-1:0]       r_wdata;
    logic [3:0]            r_cnt;
    logic [XLEN-1:0]       r_rdata;
    logic                  r_err;

    logic                  w_misaligned;
    logic                  w_accept;
    logic                  w_capture;
    logic [OB-1:0]         w_off;
    logic [7:0]            w_base;
    logic [NB-1:0]         w_mask;
    logic [XLEN-1:0]       w_wdata_sh;
    logic [XLEN-1:0]       w_rd_sh;
    logic [XLEN-1:0]       w_keep;
    logic                  w_sign;
    logic [XLEN-1:0]       w_load_ext;
    logic                  w_store_en;

    // A doubleword is only legal when the datapath is 64 bits wide.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = req_addr[0];
            2'd2:    w_misaligned = |req_addr[1:0];
            default: w_misaligned = (XLEN != 64) || (|req_addr[2:0]);
        endcase
    end

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_capture = ((r_state == ACCESS) && (LATENCY == 0)) ||
                       ((r_state == WAIT) && (r_cnt == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                w_next = (LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_off = r_addr[OB-1:0];

    always_comb begin
        w_base = 8'h01;
        case (r_size)
            2'd0:    w_base = 8'h01;
            2'd1:    w_base = 8'h03;
            2'd2:    w_base = 8'h0F;
            default: w_base = 8'hFF;
        endcase
    end

    assign w_mask     = w_base[NB-1:0] << w_off;
    assign w_wdata_sh = r_wdata << {w_off, 3'b000};
    assign w_rd_sh    = mem_rdata >> {w_off, 3'b000};

    // Keep the low 8<<size bits; everything above is either zero or the sign.
    always_comb begin
        w_keep = '1;
        w_sign = 1'b0;
        case (r_size)
            2'd0: begin
                w_keep = XLEN'(8'hFF);
                w_sign = w_rd_sh[7];
            end
            2'd1: begin
                w_keep = XLEN'(16'hFFFF);
                w_sign = w_rd_sh[15];
            end
            2'd2: begin
                w_keep = XLEN'(32'hFFFF_FFFF);
                w_sign = w_rd_sh[31];
            end
            default: begin
                w_keep = '1;
                w_sign = 1'b0;
            end
        endcase
    end

    assign w_load_ext = (w_rd_sh & w_keep) | ((w_sign && !r_uns) ? ~w_keep : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_size  <= 2'd0;
            r_wen   <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_wen   <= req_wen;
                r_uns   <= req_unsigned;
                r_wdata <= req_wdata;
                r_err   <= w_misaligned;
                r_rdata <= '0;
            end
            if (r_state == ACCESS) begin
                r_cnt <= C_LAT_M1;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rdata <= r_wen ? '0 : w_load_ext;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_store_en = mem_en && r_wen;
    assign mem_wen    = w_store_en;
    assign mem_addr   = mem_en ? {r_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}} : '0;
    assign mem_wmask  = w_store_en ? w_mask : '0;
    assign mem_wdata  = w_store_en ? w_wdata_sh : '0;

endmodule
`default_nettype wire
